// File: rtl/lut_eqn_pkg.sv
// Shared types and helpers for lut_eqn_seq and its table sub-module.
// LUT_EQN_SWEEP_EN adds the self-sweep state to the FSM encoding.
package lut_eqn_pkg;

    localparam int unsigned NInMin = 1;
    localparam int unsigned NInMax = 6;

`ifdef LUT_EQN_SWEEP_EN
    typedef enum logic [1:0] {StIdle, StLoad, StSweep} state_e;
`else
    typedef enum logic [1:0] {StIdle, StLoad} state_e;
`endif

    function automatic int unsigned depth_of(input int unsigned n);
        return 32'd1 << n;
    endfunction

endpackage

// File: rtl/lut_eqn_table.sv
// Truth-table storage: live table, load shadow, atomic commit and two read ports.
module lut_eqn_table
    import lut_eqn_pkg::*;
#(
    parameter int unsigned N_IN = 3,
    parameter logic [depth_of(N_IN)-1:0] TABLE_INIT = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            wr_en,
    input  logic [N_IN-1:0] wr_addr,
    input  logic            wr_bit,
    input  logic            commit,
    input  logic [N_IN-1:0] eval_addr,
    output logic            eval_bit,
    input  logic [N_IN-1:0] sweep_addr,
    output logic            sweep_bit
);

    localparam int unsigned DEPTH = depth_of(N_IN);

    logic [DEPTH-1:0] tbl_q;
    logic [DEPTH-1:0] shadow_q;
    logic [DEPTH-1:0] shadow_d;

    // The final beat is merged here so the commit sees the complete table.
    always_comb begin
        shadow_d = shadow_q;
        if (wr_en) begin
            shadow_d[wr_addr] = wr_bit;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tbl_q    <= TABLE_INIT;
            shadow_q <= '0;
        end else begin
            shadow_q <= shadow_d;
            if (commit) begin
                tbl_q <= shadow_d;
            end
        end
    end

    assign eval_bit  = tbl_q[eval_addr];
    assign sweep_bit = tbl_q[sweep_addr];

endmodule

// File: rtl/lut_eqn_seq.sv
// Run-time loadable N-input LUT with registered evaluation and serial load.
// Define LUT_EQN_SWEEP_EN to build the self-sweep that captures the full response.
module lut_eqn_seq
    import lut_eqn_pkg::*;
#(
    parameter int unsigned N_IN = 3,
    parameter logic [depth_of(N_IN)-1:0] TABLE_INIT = 8'h96
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_IN-1:0]           in_vec,
    input  logic                      in_valid,
    output logic                      out_f,
    output logic                      out_valid,
    input  logic                      cfg_start,
    input  logic                      cfg_valid,
    input  logic                      cfg_bit,
    output logic                      cfg_busy,
    output logic                      cfg_done,
    input  logic                      sweep_start,
    output logic                      sweep_busy,
    output logic                      sweep_done,
    output logic [depth_of(N_IN)-1:0] sweep_sig
);

    if (N_IN < NInMin || N_IN > NInMax) begin : g_bad_n_in
        $error("lut_eqn_seq: N_IN out of range");
    end

    state_e          state_q;
    logic [N_IN-1:0] cnt_q;
    logic            cnt_last;
    logic            wr_en;
    logic            commit;
    logic            eval_bit;
    logic            sweep_bit;

    assign cnt_last = (cnt_q == {N_IN{1'b1}});
    assign wr_en    = (state_q == StLoad) && cfg_valid;
    assign commit   = wr_en && cnt_last;

    lut_eqn_table #(
        .N_IN       (N_IN),
        .TABLE_INIT (TABLE_INIT)
    ) u_table (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wr_en),
        .wr_addr    (cnt_q),
        .wr_bit     (cfg_bit),
        .commit     (commit),
        .eval_addr  (in_vec),
        .eval_bit   (eval_bit),
        .sweep_addr (cnt_q),
        .sweep_bit  (sweep_bit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            out_f      <= 1'b0;
            out_valid  <= 1'b0;
            cfg_busy   <= 1'b0;
            cfg_done   <= 1'b0;
`ifdef LUT_EQN_SWEEP_EN
            sweep_busy <= 1'b0;
            sweep_done <= 1'b0;
            sweep_sig  <= '0;
`endif
        end else begin
            out_valid  <= 1'b0;
            cfg_done   <= 1'b0;
`ifdef LUT_EQN_SWEEP_EN
            sweep_done <= 1'b0;
`endif
            // Evaluation in the start cycle still reads the pre-load table.
            if (state_q == StIdle && in_valid) begin
                out_f     <= eval_bit;
                out_valid <= 1'b1;
            end
            unique case (state_q)
                StIdle: begin
                    if (cfg_start) begin
                        state_q  <= StLoad;
                        cnt_q    <= '0;
                        cfg_busy <= 1'b1;
                    end
`ifdef LUT_EQN_SWEEP_EN
                    else if (sweep_start) begin
                        state_q    <= StSweep;
                        cnt_q      <= '0;
                        sweep_busy <= 1'b1;
                    end
`endif
                end
                StLoad: begin
                    if (cfg_valid) begin
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_last) begin
                            state_q  <= StIdle;
                            cfg_busy <= 1'b0;
                            cfg_done <= 1'b1;
                        end
                    end
                end
`ifdef LUT_EQN_SWEEP_EN
                StSweep: begin
                    sweep_sig[cnt_q] <= sweep_bit;
                    cnt_q            <= cnt_q + 1'b1;
                    if (cnt_last) begin
                        state_q    <= StIdle;
                        sweep_busy <= 1'b0;
                        sweep_done <= 1'b1;
                    end
                end
`endif
                default: state_q <= StIdle;
            endcase
        end
    end

`ifndef LUT_EQN_SWEEP_EN
    logic unused_sweep;
    assign unused_sweep = ^{sweep_start, sweep_bit};
    assign sweep_busy   = 1'b0;
    assign sweep_done   = 1'b0;
    assign sweep_sig    = '0;
`endif

endmodule

// File: tb/tb_lut_eqn_seq.sv
// Randomized self-checking bench for lut_eqn_seq (N_IN = 3) against a truth-table model.
module tb_lut_eqn_seq;

    logic       clk;
    logic       rst_n;
    logic [2:0] in_vec;
    logic       in_valid;
    logic       out_f;
    logic       out_valid;
    logic       cfg_start;
    logic       cfg_valid;
    logic       cfg_bit;
    logic       cfg_busy;
    logic       cfg_done;
    logic       sweep_start;
    logic       sweep_busy;
    logic       sweep_done;
    logic [7:0] sweep_sig;

    int tests;
    int fails;

    // Reference model: the function's truth table and the value out_f should hold.
    logic [7:0] model_tbl;
    logic       exp_f;

    lut_eqn_seq #(
        .N_IN       (3),
        .TABLE_INIT (8'h96)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_vec      (in_vec),
        .in_valid    (in_valid),
        .out_f       (out_f),
        .out_valid   (out_valid),
        .cfg_start   (cfg_start),
        .cfg_valid   (cfg_valid),
        .cfg_bit     (cfg_bit),
        .cfg_busy    (cfg_busy),
        .cfg_done    (cfg_done),
        .sweep_start (sweep_start),
        .sweep_busy  (sweep_busy),
        .sweep_done  (sweep_done),
        .sweep_sig   (sweep_sig)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        tests++;
        if ({out_f, out_valid, cfg_busy, cfg_done, sweep_busy, sweep_done} !== 6'b0) begin
            fails++;
            $display("FAIL reset_outputs: got %b want 000000",
                     {out_f, out_valid, cfg_busy, cfg_done, sweep_busy, sweep_done});
        end
        rst_n = 1'b1;
        tick();
        tests++;
        if (sweep_sig !== 8'h00 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_release: sweep_sig=%h out_valid=%b want 00/0", sweep_sig,
                     out_valid);
        end
        model_tbl = 8'h96;
        exp_f     = 1'b0;
    endtask

    task automatic test_eval_all(input string nm);
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_vec   = 3'(i);
            tick();
            exp_f = model_tbl[i];
            tests++;
            if (out_valid !== 1'b1 || out_f !== exp_f) begin
                fails++;
                $display("FAIL %s code %0d: out_valid=%b out_f=%b want 1/%b", nm, i, out_valid,
                         out_f, exp_f);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_random_eval(input int n);
        logic       v;
        logic [2:0] c;
        int         bad;
        bad = 0;
        for (int i = 0; i < n; i++) begin
            v        = 1'($urandom_range(0, 1));
            c        = 3'($urandom_range(0, 7));
            in_valid = v;
            in_vec   = c;
            tick();
            if (v) exp_f = model_tbl[c];
            if (out_valid !== v || out_f !== exp_f) begin
                bad++;
                $display("FAIL random_eval step %0d: out_valid=%b out_f=%b want %b/%b", i,
                         out_valid, out_f, v, exp_f);
            end
        end
        in_valid = 1'b0;
        tests++;
        if (bad != 0) fails++;
    endtask

    task automatic test_load(input logic [7:0] val, input int nbub);
        int         cyc;
        int         left;
        logic       early;
        logic [2:0] c;
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        cyc       = 1;
        early     = 1'b0;
        left      = nbub;
        tests++;
        if (cfg_busy !== 1'b1) begin
            fails++;
            $display("FAIL load_busy_start: cfg_busy=%b want 1", cfg_busy);
        end
        for (int k = 0; k < 8; k++) begin
            while (left > 0 && (k == 7 || $urandom_range(0, 1) == 1)) begin
                cfg_valid = 1'b0;
                tick();
                cyc++;
                left--;
                if (cfg_done !== 1'b0 || cfg_busy !== 1'b1) early = 1'b1;
            end
            cfg_valid = 1'b1;
            cfg_bit   = val[k];
            tick();
            cyc++;
            if (k < 7 && (cfg_done !== 1'b0 || cfg_busy !== 1'b1)) early = 1'b1;
        end
        cfg_valid = 1'b0;
        tests++;
        if (early !== 1'b0) begin
            fails++;
            $display("FAIL load_early_done: saw busy drop/done before last beat, want none");
        end
        tests++;
        if (cfg_done !== 1'b1 || cfg_busy !== 1'b0 || cyc != 9 + nbub) begin
            fails++;
            $display("FAIL load_done: done=%b busy=%b at cycle %0d want 1/0 at %0d", cfg_done,
                     cfg_busy, cyc, 9 + nbub);
        end
        model_tbl = val;
        // Evaluation in the cfg_done cycle must already see the new table.
        c        = 3'($urandom_range(0, 7));
        in_valid = 1'b1;
        in_vec   = c;
        tick();
        in_valid = 1'b0;
        exp_f    = model_tbl[c];
        tests++;
        if (out_valid !== 1'b1 || out_f !== exp_f || cfg_done !== 1'b0) begin
            fails++;
            $display("FAIL load_done_eval code %0d: valid=%b f=%b done=%b want 1/%b/0", c,
                     out_valid, out_f, cfg_done, exp_f);
        end
    endtask

    task automatic test_majority_eval();
        in_valid = 1'b1;
        in_vec   = 3'b011;
        tick();
        tests++;
        if (out_valid !== 1'b1 || out_f !== 1'b1) begin
            fails++;
            $display("FAIL majority_011: valid=%b f=%b want 1/1", out_valid, out_f);
        end
        in_vec = 3'b001;
        tick();
        in_valid = 1'b0;
        exp_f    = 1'b0;
        tests++;
        if (out_valid !== 1'b1 || out_f !== 1'b0) begin
            fails++;
            $display("FAIL majority_001: valid=%b f=%b want 1/0", out_valid, out_f);
        end
    endtask

`ifdef LUT_EQN_SWEEP_EN
    task automatic test_sweep();
        int   n;
        logic ov_seen;
        sweep_start = 1'b1;
        tick();
        sweep_start = 1'b0;
        n           = 0;
        ov_seen     = 1'b0;
        while (sweep_busy === 1'b1 && n < 20) begin
            in_valid = 1'b1;
            in_vec   = 3'($urandom_range(0, 7));
            tick();
            n++;
            if (out_valid !== 1'b0) ov_seen = 1'b1;
        end
        in_valid = 1'b0;
        tests++;
        if (n != 8 || sweep_done !== 1'b1) begin
            fails++;
            $display("FAIL sweep_timing: busy cycles=%0d done=%b want 8/1", n, sweep_done);
        end
        tests++;
        if (sweep_sig !== model_tbl) begin
            fails++;
            $display("FAIL sweep_sig: got %h want %h", sweep_sig, model_tbl);
        end
        tests++;
        if (ov_seen !== 1'b0) begin
            fails++;
            $display("FAIL sweep_in_valid_ignored: out_valid seen during sweep, want none");
        end
        tick();
        tests++;
        if (sweep_done !== 1'b0 || sweep_sig !== model_tbl) begin
            fails++;
            $display("FAIL sweep_hold: done=%b sig=%h want 0/%h", sweep_done, sweep_sig,
                     model_tbl);
        end
    endtask

    task automatic test_sweep_reset();
        sweep_start = 1'b1;
        tick();
        sweep_start = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #2;
        tests++;
        if (sweep_sig !== 8'h00 || sweep_busy !== 1'b0) begin
            fails++;
            $display("FAIL sweep_reset: sig=%h busy=%b want 00/0", sweep_sig, sweep_busy);
        end
        rst_n     = 1'b1;
        model_tbl = 8'h96;
        exp_f     = 1'b0;
        tick();
    endtask
`else
    task automatic test_sweep();
        logic bad;
        sweep_start = 1'b1;
        tick();
        sweep_start = 1'b0;
        bad         = 1'b0;
        repeat (12) begin
            if (sweep_busy !== 1'b0 || sweep_done !== 1'b0) bad = 1'b1;
            tick();
        end
        tests++;
        if (bad !== 1'b0 || sweep_sig !== 8'h00) begin
            fails++;
            $display("FAIL sweep_disabled: activity=%b sig=%h want 0/00", bad, sweep_sig);
        end
    endtask

    task automatic test_sweep_reset();
    endtask
`endif

    task automatic test_collision();
        logic [7:0] old_tbl;
        logic [7:0] new_tbl;
        logic       sb_seen;
        old_tbl     = model_tbl;
        new_tbl     = 8'($urandom);
        cfg_start   = 1'b1;
        sweep_start = 1'b1;
        in_valid    = 1'b1;
        in_vec      = 3'd5;
        tick();
        cfg_start   = 1'b0;
        exp_f       = old_tbl[5];
        tests++;
        if (out_valid !== 1'b1 || out_f !== exp_f) begin
            fails++;
            $display("FAIL collision_eval_old: valid=%b f=%b want 1/%b", out_valid, out_f, exp_f);
        end
        tests++;
        if (cfg_busy !== 1'b1 || sweep_busy !== 1'b0) begin
            fails++;
            $display("FAIL collision_load_wins: cfg_busy=%b sweep_busy=%b want 1/0", cfg_busy,
                     sweep_busy);
        end
        // Still asserting sweep_start and in_valid inside LOAD: both must be ignored.
        in_vec = 3'd2;
        tick();
        in_valid    = 1'b0;
        sweep_start = 1'b0;
        tests++;
        if (out_valid !== 1'b0 || out_f !== exp_f) begin
            fails++;
            $display("FAIL load_in_valid_ignored: valid=%b f=%b want 0/%b", out_valid, out_f,
                     exp_f);
        end
        sb_seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            cfg_valid = 1'b1;
            cfg_bit   = new_tbl[k];
            tick();
            if (sweep_busy !== 1'b0) sb_seen = 1'b1;
        end
        cfg_valid = 1'b0;
        tests++;
        if (cfg_done !== 1'b1 || sb_seen !== 1'b0) begin
            fails++;
            $display("FAIL collision_load_done: done=%b sweep_seen=%b want 1/0", cfg_done,
                     sb_seen);
        end
        model_tbl = new_tbl;
        tick();
    endtask

    task automatic test_reset_midload();
        logic [7:0] junk;
        junk      = 8'h69;
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cfg_valid = 1'b1;
            cfg_bit   = junk[k];
            tick();
        end
        cfg_valid = 1'b0;
        rst_n     = 1'b0;
        #2;
        tests++;
        if (cfg_busy !== 1'b0 || out_f !== 1'b0) begin
            fails++;
            $display("FAIL midload_reset: busy=%b f=%b want 0/0", cfg_busy, out_f);
        end
        rst_n     = 1'b1;
        model_tbl = 8'h96;
        exp_f     = 1'b0;
        tick();
        test_eval_all("midload_table");
    endtask

    initial begin
        tests       = 0;
        fails       = 0;
        rst_n       = 1'b0;
        in_vec      = '0;
        in_valid    = 1'b0;
        cfg_start   = 1'b0;
        cfg_valid   = 1'b0;
        cfg_bit     = 1'b0;
        sweep_start = 1'b0;
        model_tbl   = 8'h96;
        exp_f       = 1'b0;

        test_reset();
        test_eval_all("init_parity");
        test_random_eval(40);
        test_load(8'hE8, 2);
        test_majority_eval();
        test_sweep();
        test_collision();
        test_random_eval(30);
        test_load(8'($urandom), 0);
        test_sweep();
        test_load(8'($urandom), 5);
        test_random_eval(30);
        test_reset_midload();
        test_sweep_reset();
        test_random_eval(20);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
